uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//  Serialises bytes from an internal transmit FIFO onto stx_pad_o in 16550 framing (start, 5-8 data LSB-first, opt parity, 1/1.5/2 stop).
//  Paced by the shared 16x baud strobe 'enable'; sits beside uart_receiver under the UART register block, which supplies lcr and push data.
// PARAMETERS
//  FIFO_DEPTH  16  transmit FIFO entries (power of 2)
//  FIFO_CNT_W  5   width of tf_count = log2(FIFO_DEPTH)+1
// PORTS
//  clk          in   1          system clock
//  wb_rst_ni    in   1          reset, asynchronous, active-low
//  lcr          in   8          line control: [1:0] wlen(5..8) [2] stb [3] PE [4] EP [5] SP [6] BC
//  enable       in   1          16x baud strobe, one clk wide
//  tf_push      in   1          write wb_dat_i into FIFO this clk
//  wb_dat_i     in   8          push data
//  tx_reset     in   1          sync clear: FIFO, overrun, state machine
//  stx_pad_o    out  1          serial line, idle high
//  tf_count     out  FIFO_CNT_W FIFO occupancy 0..FIFO_DEPTH
//  tf_overrun   out  1          sticky: push attempted while full
//  tstate       out  3          current FSM state (for LSR TEMT/THRE logic)
// BEHAVIOUR
//  Reset (wb_rst_ni=0, any time): stx_pad_o=1, tf_count=0, tf_overrun=0, tstate=IDLE, bit counters 0, FIFO pointers 0.
//  tx_reset=1: same values next clk, aborts frame mid-bit; overrides tf_push on that clk.
//  FIFO: push when tf_count<FIFO_DEPTH stores data; push when full drops data, sets tf_overrun (until tx_reset/reset).
//   Push+pop same clk: both take effect, count unchanged (also when full). Pop of empty never occurs.
//  FSM states (tstate): IDLE=0 START=1 DATA=2 PARITY=3 STOP=4. All state advance happens only on clk with enable=1.
//   bit period = 16 enable strobes; cnt16 counts 15..0 per bit, transition on enable with cnt16==0.
//  IDLE: stx_pad_o=1. On enable && tf_count!=0: pop head into shift reg, latch lcr, cnt16=15 -> START.
//   stx_pad_o falls on the clk edge that enters START (registered output, 1 clk after the popping enable).
//  START: drive 0 for 16 strobes -> DATA, bitcnt = wlen-1 (4,5,6,7 for lcr[1:0]=00..11).
//  DATA: drive shift[0]; at end of bit shift right; bitcnt==0 -> PARITY if PE else STOP, else bitcnt-1.
//  PARITY bit: SP=0,EP=1: ^data (even); SP=0,EP=0: ~^data (odd); SP=1: ~EP (stick). Only wlen bits counted.
//  STOP: drive 1 for 16 strobes (stb=0), 24 (stb=1,wlen=5), 32 (stb=1,wlen 6-8) -> IDLE.
//   Back-to-back: IDLE pops on the next enable, so idle gap between frames is exactly 1 strobe.
//  lcr latched per frame at pop; changes mid-frame take effect next frame. Exception: BC (lcr[6])=1 forces stx_pad_o=0
//   combinationally-registered (next clk) regardless of state; FSM keeps running underneath.
//  enable=0: all state, counters and stx_pad_o hold; FIFO push still works.
//  Reset mid-operation: line returns high within the async reset, no partial byte retained.
// TESTING
//  1. lcr=0x03, push 0x55, enable every 4 clk -> line: 0,1,0,1,0,1,0,1,0,1 each 16 strobes; tf_count 1->0 at pop.
//  2. lcr=0x1B (8E1), push 0x07 -> parity bit 1; lcr=0x0B (8O1) -> 0; lcr=0x3B stick -> 0; lcr=0x2B -> 1.
//  3. lcr=0x04 (5-bit,1.5 stop), push 0x1F -> 5 data ones, stop high 24 strobes, then IDLE; lcr=0x07 -> stop 32 strobes.
//  4. Push 17 bytes with enable=0 -> tf_count=16, tf_overrun=1, 17th dropped; push+pop while full keeps count 16.
//  5. Mid-DATA assert tx_reset one clk -> stx_pad_o=1, tstate=0, tf_count=0, tf_overrun=0 next clk; repeat with wb_rst_ni.
//  6. Set lcr[6] mid-frame -> stx_pad_o=0 next clk; clear -> frame resumes at current bit, completes normally.

Source files
------------

// File: rtl/uart_transmitter.sv
// 16550-style UART transmitter: 16-entry byte FIFO feeding a start/data/parity/stop
// serialiser that advances only on the shared 16x baud strobe.
module uart_transmitter #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_CNT_W = 5
) (
    input  logic                  clk,
    input  logic                  wb_rst_ni,
    input  logic [7:0]            lcr,
    input  logic                  enable,
    input  logic                  tf_push,
    input  logic [7:0]            wb_dat_i,
    input  logic                  tx_reset,
    output logic                  stx_pad_o,
    output logic [FIFO_CNT_W-1:0] tf_count,
    output logic                  tf_overrun,
    output logic [2:0]            tstate
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    logic [7:0]            fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic                  overrun_q, overrun_d;

    tx_state_e             state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [2:0]            bitCnt_q, bitCnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [5:0]            lcr_q, lcr_d;
    logic                  parity_q, parity_d;
    logic                  stx_q, stx_d;

    logic                  pop, pushOk, fifoFull;
    logic [7:0]            head, maskedHead;
    logic [4:0]            stopLen;
    logic                  unusedLcrBit;

    assign unusedLcrBit = lcr[7];

    assign fifoFull = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign head     = fifoMem_q[rdPtr_q];
    assign pop      = (state_q == IDLE) && enable && (count_q != '0) && !tx_reset;
    // A pop on the same clock frees a slot, so a push into a full FIFO still lands.
    assign pushOk   = tf_push && !tx_reset && (!fifoFull || pop);

    always_comb begin
        case (lcr[1:0])
            2'b00:   maskedHead = head & 8'h1F;
            2'b01:   maskedHead = head & 8'h3F;
            2'b10:   maskedHead = head & 8'h7F;
            default: maskedHead = head;
        endcase
    end

    assign stopLen = !lcr_q[2] ? 5'd15 : ((lcr_q[1:0] == 2'b00) ? 5'd23 : 5'd31);

    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoMem_q[wrPtr_q] <= wb_dat_i;
        end
    end

    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (tx_reset) begin
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            count_d   = '0;
            overrun_d = 1'b0;
        end else begin
            if (pushOk) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            if (pushOk && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!pushOk && pop) begin
                count_d = count_q - 1'b1;
            end
            if (tf_push && fifoFull && !pop) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        lcr_d    = lcr_q;
        parity_d = parity_q;
        stx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d  = START;
                    shift_d  = head;
                    lcr_d    = lcr[5:0];
                    parity_d = lcr[5] ? ~lcr[4] : (lcr[4] ? ^maskedHead : ~^maskedHead);
                    cnt_d    = 5'd15;
                end
            end
            START: begin
                if (enable) begin
                    if (cnt_q == 5'd0) begin
                        state_d  = DATA;
                        bitCnt_d = {1'b1, lcr_q[1:0]};
                        cnt_d    = 5'd15;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            DATA: begin
                if (enable) begin
                    if (cnt_q == 5'd0) begin
                        shift_d = {1'b0, shift_q[7:1]};
                        cnt_d   = 5'd15;
                        if (bitCnt_q == 3'd0) begin
                            if (lcr_q[3]) begin
                                state_d = PARITY;
                            end else begin
                                state_d = STOP;
                                cnt_d   = stopLen;
                            end
                        end else begin
                            bitCnt_d = bitCnt_q - 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            PARITY: begin
                if (enable) begin
                    if (cnt_q == 5'd0) begin
                        state_d = STOP;
                        cnt_d   = stopLen;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            STOP: begin
                if (enable) begin
                    if (cnt_q == 5'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line is registered from the next-state view so it changes on the entering edge.
        case (state_d)
            START:   stx_d = 1'b0;
            DATA:    stx_d = shift_d[0];
            PARITY:  stx_d = parity_d;
            default: stx_d = 1'b1;
        endcase
        if (lcr[6]) begin
            stx_d = 1'b0;
        end

        if (tx_reset) begin
            state_d  = IDLE;
            cnt_d    = '0;
            bitCnt_d = '0;
            shift_d  = '0;
            stx_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            lcr_q     <= '0;
            parity_q  <= 1'b0;
            stx_q     <= 1'b1;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            lcr_q     <= lcr_d;
            parity_q  <= parity_d;
            stx_q     <= stx_d;
        end
    end

    assign stx_pad_o  = stx_q;
    assign tf_count   = count_q;
    assign tf_overrun = overrun_q;
    assign tstate     = state_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a table of whole frames checked bit by bit,
// plus hand-written sequences for FIFO overflow, tx_reset, async reset and break.
module tb_uart_transmitter;

    logic       clk;
    logic       wb_rst_ni;
    logic [7:0] lcr;
    logic       enable;
    logic       tf_push;
    logic [7:0] wb_dat_i;
    logic       tx_reset;
    logic       stx_pad_o;
    logic [4:0] tf_count;
    logic       tf_overrun;
    logic [2:0] tstate;

    int checks;
    int errors;

    typedef struct {
        logic [7:0]  lcr;
        logic [7:0]  data;
        logic [11:0] seq;
        int          nbits;
        int          stopStr;
    } frame_t;

    frame_t tbl [8];

    uart_transmitter #(.FIFO_DEPTH(16), .FIFO_CNT_W(5)) dut (
        .clk        (clk),
        .wb_rst_ni  (wb_rst_ni),
        .lcr        (lcr),
        .enable     (enable),
        .tf_push    (tf_push),
        .wb_dat_i   (wb_dat_i),
        .tx_reset   (tx_reset),
        .stx_pad_o  (stx_pad_o),
        .tf_count   (tf_count),
        .tf_overrun (tf_overrun),
        .tstate     (tstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One baud strobe every 4 clocks; returns on a falling edge, ready to sample.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(negedge clk) enable = 1'b1;
            @(negedge clk) enable = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pushByte(input logic [7:0] d);
        @(negedge clk);
        tf_push  = 1'b1;
        wb_dat_i = d;
        @(negedge clk);
        tf_push  = 1'b0;
    endtask

    task automatic runFrame(input logic [11:0] seq, input int nbits, input int stopStr,
                            input bit doPop, input int expCount, input string tag);
        if (doPop) begin
            applyStimulus(1);
            checkOutput({tag, " start state"}, 32'(tstate), 32'd1);
            checkOutput({tag, " start line"}, 32'(stx_pad_o), 32'd0);
            checkOutput({tag, " count after pop"}, 32'(tf_count), 32'(expCount));
        end
        for (int i = 0; i < nbits; i++) begin
            applyStimulus(8);
            checkOutput($sformatf("%s bit%0d", tag, i), 32'(stx_pad_o), 32'(seq[i]));
            applyStimulus(8);
        end
        applyStimulus(stopStr - 1);
        checkOutput({tag, " stop line"}, 32'(stx_pad_o), 32'd1);
        checkOutput({tag, " stop state"}, 32'(tstate), 32'd4);
        applyStimulus(1);
        checkOutput({tag, " idle state"}, 32'(tstate), 32'd0);
        checkOutput({tag, " idle line"}, 32'(stx_pad_o), 32'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        wb_rst_ni = 1'b0;
        lcr       = 8'h03;
        enable    = 1'b0;
        tf_push   = 1'b0;
        wb_dat_i  = 8'h00;
        tx_reset  = 1'b0;

        tbl[0] = '{8'h03, 8'h55, 12'h0AA, 9,  16};
        tbl[1] = '{8'h1B, 8'h07, 12'h20E, 10, 16};
        tbl[2] = '{8'h0B, 8'h07, 12'h00E, 10, 16};
        tbl[3] = '{8'h3B, 8'h07, 12'h00E, 10, 16};
        tbl[4] = '{8'h2B, 8'h07, 12'h20E, 10, 16};
        tbl[5] = '{8'h04, 8'h1F, 12'h03E, 6,  24};
        tbl[6] = '{8'h07, 8'h1F, 12'h03E, 9,  32};
        tbl[7] = '{8'h0C, 8'hFF, 12'h03E, 7,  24};

        repeat (3) @(negedge clk);
        checkOutput("reset line", 32'(stx_pad_o), 32'd1);
        checkOutput("reset count", 32'(tf_count), 32'd0);
        checkOutput("reset overrun", 32'(tf_overrun), 32'd0);
        checkOutput("reset state", 32'(tstate), 32'd0);
        wb_rst_ni = 1'b1;

        for (int t = 0; t < 8; t++) begin
            lcr = tbl[t].lcr;
            pushByte(tbl[t].data);
            checkOutput($sformatf("frame%0d count after push", t), 32'(tf_count), 32'd1);
            runFrame(tbl[t].seq, tbl[t].nbits, tbl[t].stopStr, 1'b1, 0, $sformatf("frame%0d", t));
        end

        // FIFO overflow with the baud strobe held off, then a push racing a pop.
        lcr = 8'h03;
        for (int i = 0; i < 16; i++) begin
            pushByte(8'(8'h10 + i));
        end
        checkOutput("full count", 32'(tf_count), 32'd16);
        checkOutput("full no overrun", 32'(tf_overrun), 32'd0);
        pushByte(8'h20);
        checkOutput("overflow count", 32'(tf_count), 32'd16);
        checkOutput("overflow overrun", 32'(tf_overrun), 32'd1);
        @(negedge clk);
        tf_push  = 1'b1;
        wb_dat_i = 8'hA5;
        enable   = 1'b1;
        @(negedge clk);
        tf_push  = 1'b0;
        enable   = 1'b0;
        checkOutput("push+pop full count", 32'(tf_count), 32'd16);
        checkOutput("push+pop state", 32'(tstate), 32'd1);
        runFrame({3'b0, 8'h10, 1'b0}, 9, 16, 1'b0, 0, "drain10");
        for (int k = 1; k < 16; k++) begin
            runFrame({3'b0, 8'(8'h10 + k), 1'b0}, 9, 16, 1'b1, 16 - k, $sformatf("drain%0d", k));
        end
        runFrame({3'b0, 8'hA5, 1'b0}, 9, 16, 1'b1, 0, "drainA5");
        checkOutput("overrun sticky", 32'(tf_overrun), 32'd1);

        // tx_reset in the middle of a data bit, with a competing push.
        pushByte(8'h55);
        pushByte(8'h66);
        applyStimulus(1 + 16 + 20);
        checkOutput("pre txreset line", 32'(stx_pad_o), 32'd0);
        checkOutput("pre txreset state", 32'(tstate), 32'd2);
        @(negedge clk);
        tx_reset = 1'b1;
        tf_push  = 1'b1;
        wb_dat_i = 8'h99;
        @(negedge clk);
        tx_reset = 1'b0;
        tf_push  = 1'b0;
        checkOutput("txreset line", 32'(stx_pad_o), 32'd1);
        checkOutput("txreset state", 32'(tstate), 32'd0);
        checkOutput("txreset count", 32'(tf_count), 32'd0);
        checkOutput("txreset overrun", 32'(tf_overrun), 32'd0);

        // Asynchronous reset asserted between clock edges mid-frame.
        pushByte(8'h55);
        pushByte(8'h66);
        applyStimulus(1 + 16 + 20);
        checkOutput("pre rst line", 32'(stx_pad_o), 32'd0);
        #1 wb_rst_ni = 1'b0;
        #1;
        checkOutput("async rst line", 32'(stx_pad_o), 32'd1);
        checkOutput("async rst state", 32'(tstate), 32'd0);
        checkOutput("async rst count", 32'(tf_count), 32'd0);
        @(negedge clk) wb_rst_ni = 1'b1;

        // Break forces the line low while the frame keeps advancing underneath.
        lcr = 8'h03;
        pushByte(8'hFF);
        applyStimulus(1 + 16 + 4);
        checkOutput("pre break line", 32'(stx_pad_o), 32'd1);
        @(negedge clk) lcr = 8'h43;
        @(negedge clk);
        checkOutput("break line", 32'(stx_pad_o), 32'd0);
        applyStimulus(6);
        checkOutput("break held", 32'(stx_pad_o), 32'd0);
        checkOutput("break state", 32'(tstate), 32'd2);
        @(negedge clk) lcr = 8'h03;
        @(negedge clk);
        checkOutput("break release line", 32'(stx_pad_o), 32'd1);
        applyStimulus(6 + 7 * 16 + 15);
        checkOutput("break stop state", 32'(tstate), 32'd4);
        applyStimulus(1);
        checkOutput("break idle state", 32'(tstate), 32'd0);
        checkOutput("break idle line", 32'(stx_pad_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
